// File: rtl/display_pkg.sv
// display_pkg: shared sequencer states, default geometry and pixel record.
package display_pkg;
  localparam int DEF_WIDTH = 160;
  localparam int DEF_HEIGHT = 120;
  localparam int DEF_XW = 8;
  localparam int DEF_YW = 8;
  localparam int DEF_CW = 12;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE_PULSE} state_t;
  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
    logic [DEF_CW-1:0] color;
  } pixel_t;
endpackage

// File: rtl/raster_clear.sv
// raster_clear: raster-order X/Y counter for the screen clear, rewinding to (0,0) when idle or done.
module raster_clear #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int XW = 8,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic x_end, y_end;
  assign x_end = x == XW'(WIDTH - 1);
  assign y_end = y == YW'(HEIGHT - 1);
  assign last = x_end && y_end;
  always_ff @(posedge clk) begin
    if (rst || !run || last) begin
      x <= '0;
      y <= '0;
    end else if (x_end) begin
      x <= '0;
      y <= y_end ? y : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end
endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: clears the framebuffer, then grants the write port to each draw source in turn.
module display_sequencer
  import display_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int CW = DEF_CW,
  parameter int NUM_SRC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loop_mode,
  input  logic [CW-1:0]         clear_color,
  output logic [NUM_SRC-1:0]    src_lock,
  input  logic [NUM_SRC*XW-1:0] src_x,
  input  logic [NUM_SRC*YW-1:0] src_y,
  input  logic [NUM_SRC*CW-1:0] src_color,
  input  logic [NUM_SRC-1:0]    src_we,
  input  logic [NUM_SRC-1:0]    src_done,
  output logic [XW-1:0]         CounterX,
  output logic [YW-1:0]         CounterY,
  output logic [CW-1:0]         color,
  output logic                  we,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] clr_color, sc;
  logic [XW-1:0] rx, sx;
  logic [YW-1:0] ry, sy;
  logic rlast, swe, sdone, last_src, in_range;
  raster_clear #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_clear (
    .clk(clk), .rst(rst), .run(state == CLEAR), .x(rx), .y(ry), .last(rlast)
  );
  assign sx = src_x[idx*XW +: XW];
  assign sy = src_y[idx*YW +: YW];
  assign sc = src_color[idx*CW +: CW];
  assign swe = src_we[idx];
  assign sdone = src_done[idx];
  assign last_src = idx == IW'(NUM_SRC - 1);
  // one extra bit keeps the compare correct when WIDTH/HEIGHT equal 2**XW/2**YW
  assign in_range = ({1'b0, sx} < (XW+1)'(WIDTH)) && ({1'b0, sy} < (YW+1)'(HEIGHT));
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: state_n = start ? CLEAR : IDLE;
      CLEAR: begin
        state_n = rlast ? DRAW : CLEAR;
        idx_n = '0;
      end
      DRAW: begin
        state_n = (sdone && last_src) ? DONE_PULSE : DRAW;
        idx_n = (sdone && !last_src) ? idx + 1'b1 : idx;
      end
      DONE_PULSE: state_n = loop_mode ? CLEAR : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      clr_color <= '0;
      CounterX <= '0;
      CounterY <= '0;
      color <= '0;
      we <= 1'b0;
      busy <= 1'b0;
      src_lock <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (state == IDLE && start) clr_color <= clear_color;
      we <= 1'b0;
      if (state == CLEAR) begin
        CounterX <= rx;
        CounterY <= ry;
        color <= clr_color;
        we <= 1'b1;
      end else if (state == DRAW) begin
        CounterX <= sx;
        CounterY <= sy;
        color <= sc;
        we <= swe && in_range;
      end
      busy <= state_n != IDLE;
      src_lock <= (state_n == DRAW) ? NUM_SRC'(1) << idx_n : '0;
      frame_done <= state_n == DONE_PULSE;
    end
  end
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed, table-driven and randomized checks of display_sequencer (4x3, two sources).
module tb_display_sequencer;
  import display_pkg::*;
  logic clk = 1'b0;
  logic rst, start, loop_mode, we, busy, frame_done;
  logic [11:0] clear_color, color;
  logic [1:0] src_lock, src_we, src_done;
  logic [15:0] src_x, src_y;
  logic [23:0] src_color;
  logic [7:0] CounterX, CounterY;
  int checks = 0, errors = 0;
  display_sequencer #(.WIDTH(4), .HEIGHT(3), .XW(8), .YW(8), .CW(12), .NUM_SRC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .loop_mode(loop_mode), .clear_color(clear_color),
    .src_lock(src_lock), .src_x(src_x), .src_y(src_y), .src_color(src_color), .src_we(src_we),
    .src_done(src_done), .CounterX(CounterX), .CounterY(CounterY), .color(color), .we(we),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_src(input int k, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c,
                         input logic w, input logic d);
    src_x[k*8 +: 8] = x;
    src_y[k*8 +: 8] = y;
    src_color[k*12 +: 12] = c;
    src_we[k] = w;
    src_done[k] = d;
  endtask
  typedef struct {
    pixel_t p;
    logic w;
    logic ew;
  } vec_t;
  vec_t tbl[7];
  task automatic put(input int i, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c,
                     input logic w, input logic ew);
    tbl[i].p.x = x;
    tbl[i].p.y = y;
    tbl[i].p.color = c;
    tbl[i].w = w;
    tbl[i].ew = ew;
  endtask
  // reference model: frame phase, clear pixel index and granted source
  int ph, n, k;
  logic [11:0] cc, m_c;
  logic [7:0] m_x, m_y;
  logic m_we;
  task automatic model_step();
    if (rst) begin
      ph = 0; n = 0; k = 0; cc = 0; m_x = 0; m_y = 0; m_c = 0; m_we = 0;
    end else begin
      m_we = 0;
      case (ph)
        0: if (start) begin ph = 1; n = 0; cc = clear_color; end
        1: begin
          m_x = 8'(n % 4); m_y = 8'(n / 4); m_c = cc; m_we = 1; n++;
          if (n == 12) begin ph = 2; k = 0; end
        end
        2: begin
          m_x = src_x[k*8 +: 8]; m_y = src_y[k*8 +: 8]; m_c = src_color[k*12 +: 12];
          m_we = src_we[k] && m_x < 4 && m_y < 3;
          if (src_done[k]) begin
            if (k == 1) ph = 3;
            else k++;
          end
        end
        default: begin ph = loop_mode ? 1 : 0; n = 0; end
      endcase
    end
  endtask
  initial begin
    int cnt;
    rst = 1; start = 0; loop_mode = 0; clear_color = 0;
    src_x = 0; src_y = 0; src_color = 0; src_we = 0; src_done = 0;
    tick(); tick();
    chk("rst_out", {we, busy, src_lock, frame_done, CounterX, CounterY, color}, 0);
    rst = 0;
    // frame with red clear
    start = 1; clear_color = 12'hF00;
    tick();
    start = 0; clear_color = 12'h000;
    chk("busy_after_start", {busy, we}, 2'b10);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("clear_px", {we, CounterX, CounterY, color}, {1'b1, 8'(i % 4), 8'(i / 4), 12'hF00});
    end
    chk("lock_src0", src_lock, 2'b01);
    tick();
    chk("we_after_clear", we, 0);
    // range checks on source 0; source 1 strobes and done must be ignored
    put(0, 0, 0, 12'h001, 1, 1);
    put(1, 3, 2, 12'h002, 1, 1);
    put(2, 4, 0, 12'h003, 1, 0);
    put(3, 0, 3, 12'h004, 1, 0);
    put(4, 255, 255, 12'h005, 1, 0);
    put(5, 3, 2, 12'h006, 0, 0);
    put(6, 1, 2, 12'h007, 1, 1);
    for (int i = 0; i < 7; i++) begin
      set_src(0, tbl[i].p.x, tbl[i].p.y, tbl[i].p.color, tbl[i].w, 0);
      set_src(1, 1, 1, 12'h123, 1, 1);
      tick();
      chk("tbl_out", {we, CounterX, CounterY, color}, {tbl[i].ew, tbl[i].p});
      chk("tbl_lock", src_lock, 2'b01);
    end
    // write with done on the same cycle
    set_src(1, 0, 0, 0, 0, 0);
    set_src(0, 2, 1, 12'h0F0, 1, 1);
    tick();
    chk("done_write", {we, CounterX, CounterY, color}, {1'b1, 8'd2, 8'd1, 12'h0F0});
    chk("lock_src1", src_lock, 2'b10);
    set_src(0, 0, 0, 0, 1, 1);
    set_src(1, 5, 1, 12'h00F, 1, 0);
    tick();
    chk("oor_x", {we, CounterX}, {1'b0, 8'd5});
    set_src(1, 1, 7, 12'h00F, 1, 0);
    tick();
    chk("oor_y", {we, CounterY}, {1'b0, 8'd7});
    set_src(1, 0, 0, 0, 0, 1);
    tick();
    set_src(1, 0, 0, 0, 0, 0);
    set_src(0, 0, 0, 0, 0, 0);
    chk("frame_done", {frame_done, busy, src_lock}, {1'b1, 1'b1, 2'b00});
    tick();
    chk("back_idle", {frame_done, busy, we}, 0);
    // continuous mode
    loop_mode = 1; start = 1; clear_color = 12'h00F;
    tick();
    start = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (we) cnt++; end
    chk("loop_clear_cnt", cnt, 12);
    src_done = 2'b01; tick();
    src_done = 2'b10; tick();
    src_done = 2'b00;
    chk("loop_fd", frame_done, 1);
    tick();
    chk("loop_restart", {busy, frame_done, we, src_lock}, {1'b1, 1'b0, 1'b0, 2'b00});
    tick();
    chk("loop_px0", {we, CounterX, CounterY, color}, {1'b1, 8'd0, 8'd0, 12'h00F});
    // reset in the middle of clear
    for (int i = 0; i < 6; i++) tick();
    chk("at_21", {CounterX, CounterY}, {8'd2, 8'd1});
    rst = 1; tick(); rst = 0;
    chk("mid_rst", {we, busy, src_lock, frame_done}, 0);
    loop_mode = 0; start = 1; clear_color = 12'h0AB;
    tick(); start = 0;
    tick();
    chk("restart_px0", {we, CounterX, CounterY, color}, {1'b1, 8'd0, 8'd0, 12'h0AB});
    // start pulses while busy
    cnt = 1;
    for (int j = 0; j < 30; j++) begin
      start = (j % 3 == 0);
      tick();
      if (we) cnt++;
      if (src_lock != 0) break;
    end
    start = 0;
    chk("busy_start_cnt", cnt, 12);
    chk("busy_start_last", {CounterX, CounterY}, {8'd3, 8'd2});
    start = 1; src_done = 2'b01; tick();
    src_done = 2'b10; tick();
    src_done = 2'b00; start = 0;
    chk("busy_start_fd", frame_done, 1);
    tick();
    chk("busy_start_idle", busy, 0);
    // randomized run against the model
    rst = 1; model_step(); tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) loop_mode = ~loop_mode;
      clear_color = 12'($urandom);
      for (int s = 0; s < 2; s++)
        set_src(s, 8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)), 12'($urandom),
                1'($urandom), $urandom_range(0, 5) == 0);
      model_step();
      tick();
      chk("rand", {busy, src_lock, frame_done, we, CounterX, CounterY, color},
          {ph != 0, (ph == 2) ? 2'(1 << k) : 2'b00, ph == 3, m_we, m_x, m_y, m_c});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
